// File: rtl/raw_bayer_tx.sv
// rtl/raw_bayer_tx.sv - RGB-to-Bayer re-mosaic camera emulator with D8M-style framing
//
// Accepts 8-bit RGB pixels over a valid/ready handshake and emits a 10-bit
// Bayer raw stream with frame/line framing, for sensor-less ISP self-test.
//
// Ports:
//   CLK, RST_N        pixel clock, asynchronous active-low reset
//   ENABLE            frame generation enable, sampled at frame boundaries
//   iR, iG, iB        input pixel colour (8 bits each)
//   iVALID / oREADY   input handshake; oREADY is high the cycle before each line slot
//   CCD_DATA          10-bit Bayer sample, 0 outside active line
//   CCD_FVAL/CCD_LVAL frame / line valid
//   DVAL              CCD_FVAL && CCD_LVAL
//   X_Cont, Y_Cont    column / row of the current sample
//   oUNDERRUN         sticky: a slot had no valid input this frame
//   oFRAME_DONE       one-cycle pulse on the FVAL falling edge
module raw_bayer_tx #(
  parameter int         H_ACTIVE  = 640,
  parameter int         V_ACTIVE  = 480,
  parameter int         H_BLANK   = 160,
  parameter int         V_BLANK   = 20,
  parameter int         FV_LV_GAP = 4,
  parameter logic [1:0] PATTERN   = 2'd1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  input  logic        iVALID,
  output logic        oREADY,
  output logic [9:0]  CCD_DATA,
  output logic        CCD_FVAL,
  output logic        CCD_LVAL,
  output logic        DVAL,
  output logic [15:0] X_Cont,
  output logic [15:0] Y_Cont,
  output logic        oUNDERRUN,
  output logic        oFRAME_DONE
);

  localparam logic [31:0] VB_LAST  = 32'(V_BLANK * (H_ACTIVE + H_BLANK) - 1);
  localparam logic [31:0] GAP_LAST = 32'(FV_LV_GAP - 1);
  localparam logic [31:0] H_LAST   = 32'(H_ACTIVE - 1);
  localparam logic [31:0] HB_LAST  = 32'(H_BLANK - 1);
  localparam logic [15:0] V_LAST   = 16'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VBLANK,
    S_FV_PRE,
    S_LINE,
    S_HBLANK,
    S_FV_POST
  } state_t;

  state_t      state, state_d;
  logic [31:0] cnt, cnt_d;

  logic [15:0] x_q, y_q, x_d, y_d;
  logic [9:0]  data_q, data_d;
  logic        fval_q, lval_q, done_q, underrun_q;
  logic        fval_d, underrun_d, ready;
  logic        px, py;
  logic [7:0]  pix;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // cnt counts cycles spent in the current state and restarts on every transition.
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 32'd1;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (ENABLE) state_d = S_VBLANK;
      end
      S_VBLANK: begin
        if (cnt == VB_LAST) begin
          state_d = S_FV_PRE;
          cnt_d   = '0;
        end
      end
      S_FV_PRE: begin
        if (cnt == GAP_LAST) begin
          state_d = S_LINE;
          cnt_d   = '0;
        end
      end
      S_LINE: begin
        if (cnt == H_LAST) begin
          state_d = (y_q == V_LAST) ? S_FV_POST : S_HBLANK;
          cnt_d   = '0;
        end
      end
      S_HBLANK: begin
        if (cnt == HB_LAST) begin
          state_d = S_LINE;
          cnt_d   = '0;
        end
      end
      S_FV_POST: begin
        // ENABLE is only consulted here, so a mid-frame drop never cuts a frame short.
        if (cnt == GAP_LAST) begin
          state_d = ENABLE ? S_VBLANK : S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Everything below is computed for the cycle that state_d describes and then
  // registered, so the accepted pixel lands in its slot one edge later.
  always_comb begin
    ready  = (state_d == S_LINE);
    fval_d = (state_d != S_IDLE) && (state_d != S_VBLANK);

    x_d = '0;
    if (ready && state == S_LINE) x_d = x_q + 16'd1;

    y_d = '0;
    if (fval_d) y_d = (state == S_HBLANK && ready) ? y_q + 16'd1 : y_q;

    // Non-RGGB orders are RGGB with the column and/or row parity flipped.
    px = x_d[0] ^ PATTERN[0];
    py = y_d[0] ^ PATTERN[1];
    case ({py, px})
      2'b00:   pix = iR;
      2'b11:   pix = iB;
      default: pix = iG;
    endcase

    data_d = '0;
    if (ready && iVALID) data_d = {pix, pix[7:6]};

    // Clear wins over a same-cycle set.
    underrun_d = underrun_q;
    if (ready && !iVALID) underrun_d = 1'b1;
    if (state == S_VBLANK && state_d == S_FV_PRE) underrun_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fval_q     <= 1'b0;
      lval_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      data_q     <= '0;
    end else begin
      fval_q     <= fval_d;
      lval_q     <= ready;
      done_q     <= (state == S_FV_POST) && (state_d != S_FV_POST);
      underrun_q <= underrun_d;
      x_q        <= x_d;
      y_q        <= y_d;
      data_q     <= data_d;
    end
  end

  assign oREADY      = ready;
  assign CCD_DATA    = data_q;
  assign CCD_FVAL    = fval_q;
  assign CCD_LVAL    = lval_q;
  assign DVAL        = fval_q & lval_q;
  assign X_Cont      = x_q;
  assign Y_Cont      = y_q;
  assign oUNDERRUN   = underrun_q;
  assign oFRAME_DONE = done_q;

endmodule

// File: tb/tb_raw_bayer_tx.sv
// tb/tb_raw_bayer_tx.sv - directed self-checking bench for raw_bayer_tx (4x2 frame, all four Bayer orders)
module tb_raw_bayer_tx;

  logic       CLK;
  logic       RST_N;
  logic       ENABLE;
  logic [7:0] iR, iG, iB;
  logic       iVALID;

  logic        rdy   [4];
  logic [9:0]  data  [4];
  logic        fval  [4];
  logic        lval  [4];
  logic        dval  [4];
  logic [15:0] xc    [4];
  logic [15:0] yc    [4];
  logic        und   [4];
  logic        done  [4];

  for (genvar p = 0; p < 4; p++) begin : g_dut
    raw_bayer_tx #(
      .H_ACTIVE (4),
      .V_ACTIVE (2),
      .H_BLANK  (2),
      .V_BLANK  (1),
      .FV_LV_GAP(1),
      .PATTERN  (2'(p))
    ) u_dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .ENABLE     (ENABLE),
      .iR         (iR),
      .iG         (iG),
      .iB         (iB),
      .iVALID     (iVALID),
      .oREADY     (rdy[p]),
      .CCD_DATA   (data[p]),
      .CCD_FVAL   (fval[p]),
      .CCD_LVAL   (lval[p]),
      .DVAL       (dval[p]),
      .X_Cont     (xc[p]),
      .Y_Cont     (yc[p]),
      .oUNDERRUN  (und[p]),
      .oFRAME_DONE(done[p])
    );
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected samples for iR=FF, iG=80, iB=00, slots k = y*4 + x.
  logic [9:0] exp_tab [4][8];
  // Colour at site (row parity*2 + column parity): 0=R, 1=G, 2=B.
  logic [1:0] site_col [4][4];

  logic [9:0] cap [4][8];
  int cap_cnt, done_cnt, rdy_cnt, run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_fval_rise(output int n);
    n = 0;
    while (fval[0] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Runs from the FVAL-rise sample to one cycle past the FVAL fall.
  task automatic capture(input int drop_acc, input bit ramp, input int dis_at);
    int guard;
    int xs, ys;
    guard = 0; cap_cnt = 0; done_cnt = 0; rdy_cnt = 0; run = 0;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 8; k++) cap[p][k] = 'x;
    while (fval[0] === 1'b1 && guard < 400) begin
      if (guard == dis_at) ENABLE = 1'b0;
      if (dval[0] === 1'b1) begin
        if (cap_cnt < 8) begin
          for (int p = 0; p < 4; p++) cap[p][cap_cnt] = data[p];
          check($sformatf("x_cont k%0d", cap_cnt), 32'(xc[0]), 32'(cap_cnt % 4));
          check($sformatf("y_cont k%0d", cap_cnt), 32'(yc[0]), 32'(cap_cnt / 4));
        end
        cap_cnt++;
      end
      if (lval[0] === 1'b1) run++;
      else if (run != 0) begin
        check("lval_width", 32'(run), 32'd4);
        run = 0;
      end
      done_cnt += int'(done[0]);
      iVALID = 1'b1;
      if (rdy[0] === 1'b1) begin
        xs = rdy_cnt % 4;
        ys = rdy_cnt / 4;
        if (ramp) begin
          iR = 8'(xs);
          iG = 8'(ys);
          iB = 8'(xs + ys);
        end
        if (rdy_cnt == drop_acc) iVALID = 1'b0;
        rdy_cnt++;
      end
      tick();
      guard++;
    end
    check("fval_fall_in_time", 32'(fval[0]), 32'd0);
    done_cnt += int'(done[0]);
    tick();
    done_cnt += int'(done[0]);
  endtask

  task automatic check_frame(input string tag, input bit ramp, input int drop_acc);
    int x, y, c;
    logic [9:0] e;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 8; k++) begin
        x = k % 4;
        y = k / 4;
        if (ramp) begin
          case (site_col[p][(y % 2) * 2 + (x % 2)])
            2'd0:    c = x;
            2'd1:    c = y;
            default: c = x + y;
          endcase
          e = 10'(c * 4);  // ramp values stay below 64, so the two LSBs are 0
        end else begin
          e = exp_tab[p][k];
        end
        if (k == drop_acc) e = 10'h000;
        check($sformatf("%s p%0d k%0d", tag, p, k), 32'(cap[p][k]), 32'(e));
      end
    end
    check({tag, " dval_count"}, 32'(cap_cnt), 32'd8);
    check({tag, " ready_count"}, 32'(rdy_cnt), 32'd8);
    check({tag, " frame_done"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int n, hi;

    exp_tab[0] = '{10'h3FF, 10'h202, 10'h3FF, 10'h202, 10'h202, 10'h000, 10'h202, 10'h000};
    exp_tab[1] = '{10'h202, 10'h3FF, 10'h202, 10'h3FF, 10'h000, 10'h202, 10'h000, 10'h202};
    exp_tab[2] = '{10'h202, 10'h000, 10'h202, 10'h000, 10'h3FF, 10'h202, 10'h3FF, 10'h202};
    exp_tab[3] = '{10'h000, 10'h202, 10'h000, 10'h202, 10'h202, 10'h3FF, 10'h202, 10'h3FF};
    site_col[0] = '{2'd0, 2'd1, 2'd1, 2'd2};
    site_col[1] = '{2'd1, 2'd0, 2'd2, 2'd1};
    site_col[2] = '{2'd1, 2'd2, 2'd0, 2'd1};
    site_col[3] = '{2'd2, 2'd1, 2'd1, 2'd0};

    RST_N = 1'b0; ENABLE = 1'b0; iVALID = 1'b0;
    iR = 8'h00; iG = 8'h00; iB = 8'h00;
    repeat (3) tick();
    check("rst fval", 32'(fval[0]), 32'd0);
    check("rst lval", 32'(lval[0]), 32'd0);
    check("rst data", 32'(data[0]), 32'd0);
    check("rst x", 32'(xc[0]), 32'd0);
    check("rst y", 32'(yc[0]), 32'd0);
    check("rst ready", 32'(rdy[0]), 32'd0);
    check("rst underrun", 32'(und[0]), 32'd0);
    check("rst done", 32'(done[0]), 32'd0);

    // Frame A: constant colour, all patterns.
    iR = 8'hFF; iG = 8'h80; iB = 8'h00; iVALID = 1'b1;
    ENABLE = 1'b1; RST_N = 1'b1;
    wait_fval_rise(n);
    check("first_fval_delay", 32'(n), 32'd7);
    capture(-1, 1'b0, -1);
    check_frame("constA", 1'b0, -1);
    check("A underrun", 32'(und[0]), 32'd0);

    // Frame B: drop iVALID on the third acceptance of line 1 (slot 6).
    wait_fval_rise(n);
    capture(6, 1'b0, -1);
    check_frame("dropB", 1'b0, 6);
    check("B underrun set", 32'(und[0]), 32'd1);
    check("B underrun set p3", 32'(und[3]), 32'd1);

    // Frame C: underrun clears at FVAL rise; ENABLE dropped mid-frame.
    wait_fval_rise(n);
    check("C underrun cleared", 32'(und[0]), 32'd0);
    capture(-1, 1'b0, 3);
    check_frame("disC", 1'b0, -1);
    hi = 0;
    repeat (20) begin
      tick();
      if (fval[0] !== 1'b0) hi++;
    end
    check("idle fval stays low", 32'(hi), 32'd0);
    ENABLE = 1'b1;
    wait_fval_rise(n);
    check("reenable_fval_delay", 32'(n), 32'd7);

    // Frame D: ramp image R=x, G=y, B=x+y.
    capture(-1, 1'b1, -1);
    check_frame("rampD", 1'b1, -1);

    // Frame E: asynchronous reset mid-line.
    iR = 8'hFF; iG = 8'h80; iB = 8'h00;
    wait_fval_rise(n);
    n = 0;
    while (!(lval[0] === 1'b1 && xc[0] == 16'd1) && n < 50) begin
      tick();
      n++;
    end
    check("E reached x1", 32'(xc[0]), 32'd1);
    #3;
    RST_N = 1'b0;
    #1;
    check("async fval", 32'(fval[0]), 32'd0);
    check("async lval", 32'(lval[0]), 32'd0);
    check("async data", 32'(data[0]), 32'd0);
    check("async x", 32'(xc[0]), 32'd0);
    check("async y", 32'(yc[0]), 32'd0);
    check("async ready", 32'(rdy[0]), 32'd0);
    tick();
    RST_N = 1'b1;
    wait_fval_rise(n);
    check("post_reset_fval_delay", 32'(n), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/raw_bayer_tx.md
Name: raw_bayer_tx

Overview:
- Camera-emulator block that takes 8-bit RGB pixels over a valid/ready handshake and re-mosaics them into a 10-bit Bayer raw stream.
- Output carries D8M-style frame/line framing: CCD_DATA, CCD_FVAL, CCD_LVAL, DVAL, X_Cont and Y_Cont.
- Feeds the raw-to-RGB line-buffer path for closed-loop self-test without the sensor, and supplies known patterns for ISP regression.
- Runs on the pixel clock domain.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- H_BLANK, 160, LVAL-low cycles between lines (min 2).
- V_BLANK, 20, full-line periods with FVAL low between frames (min 1).
- FV_LV_GAP, 4, cycles between the FVAL edge and the LVAL edge, applied before the first line and after the last line (min 1).
- PATTERN, 2'd1, Bayer order: 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR. The first letter is the colour at row 0, column 0.

Ports:
- CLK  in  1  pixel clock.
- RST_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  start/continue frame generation; sampled only at frame boundaries.
- iR / iG / iB  in  8 each  input pixel colour.
- iVALID  in  1  input pixel valid.
- oREADY  out  1  pixel accepted this cycle when iVALID && oREADY.
- CCD_DATA  out  10  Bayer sample.
- CCD_FVAL  out  1  frame valid.
- CCD_LVAL  out  1  line valid.
- DVAL  out  1  equals CCD_FVAL && CCD_LVAL.
- X_Cont  out  16  column of the current CCD_DATA; 0 outside active.
- Y_Cont  out  16  row of the current CCD_DATA; 0 outside frame.
- oUNDERRUN  out  1  sticky: an active slot had no valid input this frame.
- oFRAME_DONE  out  1  one-cycle pulse on the FVAL falling edge.

Behaviour:
- Reset values:
  - All outputs 0, state IDLE, all counters 0.
  - Reset is honoured mid-frame: FVAL and LVAL drop immediately with no trailing line.
- State machine:
  - IDLE: FVAL=0. When ENABLE=1, go to VBLANK with vcnt=0.
  - VBLANK: counts V_BLANK*(H_ACTIVE+H_BLANK) cycles. At the end, assert FVAL and go to FV_PRE.
  - FV_PRE: FVAL=1, LVAL=0 for FV_LV_GAP cycles, then go to LINE.
  - LINE: LVAL=1 for exactly H_ACTIVE cycles. At the end, go to HBLANK, or to FV_POST if this was line V_ACTIVE-1.
  - HBLANK: LVAL=0 for H_BLANK cycles, then Y_Cont+1 and go to LINE.
  - FV_POST: LVAL=0 for FV_LV_GAP cycles, then drop FVAL and pulse oFRAME_DONE.
    - If ENABLE=1, go to VBLANK; otherwise go to IDLE.
    - Deasserting ENABLE mid-frame never truncates the frame.
- Handshake:
  - oREADY is combinational and equals 1 exactly in the cycle before each LINE output slot. The accepted pixel is therefore registered into the slot.
  - Every output (CCD_DATA, LVAL, X/Y) changes only on a CLK rising edge. Latency from acceptance to CCD_DATA is 1 cycle.
- Underrun:
  - If a slot's acceptance cycle has iVALID=0, that slot outputs CCD_DATA=0 and sets oUNDERRUN.
  - Framing timing never stretches.
  - oUNDERRUN clears on the FVAL rising edge; a set and a clear in the same cycle resolve to clear.
- Mosaic selection:
  - px = X_Cont[0], py = Y_Cont[0]; the site index is {py, px}.
  - For RGGB, site 00 selects R, 01 and 10 select G, 11 selects B. The other patterns are RGGB with px and/or py inverted:
    - GRBG inverts px.
    - GBRG inverts py.
    - BGGR inverts both.
- 8-to-10 bit expansion: CCD_DATA = {c[7:0], c[7:6]}. For example, 8'hFF -> 10'h3FF and 8'h80 -> 10'h202.
- Counters:
  - X_Cont runs 0..H_ACTIVE-1 during LVAL and is 0 otherwise.
  - Y_Cont runs 0..V_ACTIVE-1 while FVAL=1 and wraps to 0 at FVAL fall.
- CCD_DATA is 0 whenever LVAL=0.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_BLANK=1, FV_LV_GAP=1, PATTERN=0, constant iR=8'hFF, iG=8'h80, iB=8'h00, iVALID=1:
  - Row 0 must read 3FF,202,3FF,202; row 1 must read 202,000,202,000.
  - Exactly 8 DVAL cycles and one oFRAME_DONE.
- Same stimulus with PATTERN=1, 2 and 3 -> row 0 first samples are 202, 202 and 000 respectively; checker verifies every site against the mosaic table.
- iVALID dropped for one cycle during the third acceptance of line 1:
  - That slot outputs 000 and oUNDERRUN=1 until the next FVAL rise, then 0.
  - LVAL width must remain 4.
- ENABLE dropped mid-frame -> the frame completes all V_ACTIVE lines and then stays in IDLE with FVAL=0; re-asserting ENABLE starts a new frame after the V_BLANK period.
- RST_N asserted asynchronously mid-line -> FVAL, LVAL, CCD_DATA, X_Cont, Y_Cont and oREADY go to 0 without waiting for CLK; after release the first FVAL rise follows the full V_BLANK period.
- Loopback: ramp image (R=x, G=y, B=x+y) through this block into the raw-to-RGB path -> recovered pixels for interior sites match the expected demosaic within ±1 LSB of 8-bit.
